// File: rtl/dand_bus_pkg.sv
// Shared types and defaults for the dual-master memory bus arbiter.
package dand_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_TIMEOUT = 1024;

    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;
endpackage

// File: rtl/dand_rr_arbiter2.sv
// Two-request round-robin picker; remembers the master that finished last.
import dand_bus_pkg::*;

module dand_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic       pick
);
    logic last_grant;

    // Reset to DBUS so IBUS wins the first contested round.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= DBUS;
        else if (done)
            last_grant <= done_id;
    end

    always_comb begin
        pick = IBUS;
        case (req)
            2'b01:   pick = IBUS;
            2'b10:   pick = DBUS;
            2'b11:   pick = ~last_grant;
            default: pick = IBUS;
        endcase
    end
endmodule

// File: rtl/dand_mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and data masters; a grant
// spans command and all response beats, and a watchdog aborts stalled replies.
import dand_bus_pkg::*;

module dand_mem_bus_arbiter #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  io_axiClk,
    input  logic                  io_axiReset,
    input  logic [1:0]            m_cmd_valid,
    output logic [1:0]            m_cmd_ready,
    input  logic [1:0]            m_cmd_write,
    input  logic [2*ADDR_W-1:0]   m_cmd_addr,
    input  logic [2*LEN_W-1:0]    m_cmd_len,
    input  logic [2*DATA_W-1:0]   m_cmd_wdata,
    input  logic [2*DATA_W/8-1:0] m_cmd_wstrb,
    output logic [1:0]            m_rsp_valid,
    output logic [DATA_W-1:0]     m_rsp_data,
    output logic                  m_rsp_last,
    output logic                  m_rsp_error,
    output logic                  s_cmd_valid,
    input  logic                  s_cmd_ready,
    output logic                  s_cmd_write,
    output logic [ADDR_W-1:0]     s_cmd_addr,
    output logic [LEN_W-1:0]      s_cmd_len,
    output logic [DATA_W-1:0]     s_cmd_wdata,
    output logic [DATA_W/8-1:0]   s_cmd_wstrb,
    input  logic                  s_rsp_valid,
    input  logic [DATA_W-1:0]     s_rsp_data,
    input  logic                  s_rsp_last,
    input  logic                  s_rsp_error,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  timeout_pulse
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_nxt;
    logic              gnt;
    logic              pick;
    logic [LEN_W-1:0]  beat_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              hs, beat, final_beat, abort, done;

    logic [ADDR_W-1:0]   addr_a  [2];
    logic [LEN_W-1:0]    len_a   [2];
    logic [DATA_W-1:0]   wdata_a [2];
    logic [DATA_W/8-1:0] wstrb_a [2];

    for (genvar i = 0; i < 2; i++) begin : g_unpack
        assign addr_a[i]  = m_cmd_addr[i*ADDR_W +: ADDR_W];
        assign len_a[i]   = m_cmd_len[i*LEN_W +: LEN_W];
        assign wdata_a[i] = m_cmd_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i] = m_cmd_wstrb[i*(DATA_W/8) +: DATA_W/8];
    end

    assign hs         = (state == CMD) && s_cmd_ready;
    assign beat       = (state == RSP) && s_rsp_valid;
    assign final_beat = beat && ((beat_cnt == '0) || s_rsp_last);
    assign abort      = (state == RSP) && !s_rsp_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign done       = final_beat || abort;

    dand_rr_arbiter2 u_rr (
        .clk     (io_axiClk),
        .rst     (io_axiReset),
        .req     (m_cmd_valid),
        .done    (done),
        .done_id (gnt),
        .pick    (pick)
    );

    always_ff @(posedge io_axiClk) begin
        if (io_axiReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|m_cmd_valid) state_nxt = CMD;
            CMD:     if (hs) state_nxt = RSP;
            RSP:     if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge io_axiClk) begin
        if (io_axiReset) begin
            gnt      <= IBUS;
            beat_cnt <= '0;
            wd_cnt   <= '0;
        end else begin
            if ((state == IDLE) && (|m_cmd_valid))
                gnt <= pick;
            if (hs) begin
                beat_cnt <= m_cmd_write[gnt] ? '0 : len_a[gnt];
                wd_cnt   <= '0;
            end else if (beat) begin
                if (beat_cnt != '0)
                    beat_cnt <= beat_cnt - LEN_W'(1);
                wd_cnt <= '0;
            end else if ((state == RSP) && !abort) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

    always_comb begin
        s_cmd_valid   = 1'b0;
        s_cmd_write   = m_cmd_write[gnt];
        s_cmd_addr    = addr_a[gnt];
        s_cmd_len     = len_a[gnt];
        s_cmd_wdata   = wdata_a[gnt];
        s_cmd_wstrb   = wstrb_a[gnt];
        m_cmd_ready   = 2'b00;
        m_rsp_valid   = 2'b00;
        m_rsp_data    = '0;
        m_rsp_last    = 1'b0;
        m_rsp_error   = 1'b0;
        timeout_pulse = 1'b0;
        busy          = (state != IDLE);
        grant_id      = gnt;
        case (state)
            CMD: begin
                s_cmd_valid      = 1'b1;
                m_cmd_ready[gnt] = s_cmd_ready;
            end
            RSP: begin
                if (abort) begin
                    m_rsp_valid[gnt] = 1'b1;
                    m_rsp_last       = 1'b1;
                    m_rsp_error      = 1'b1;
                    timeout_pulse    = 1'b1;
                end else begin
                    m_rsp_valid[gnt] = s_rsp_valid;
                    m_rsp_data       = s_rsp_data;
                    m_rsp_last       = final_beat;
                    // A premature slave last truncates the burst and is flagged.
                    m_rsp_error      = s_rsp_error || (s_rsp_last && (beat_cnt != '0));
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dand_mem_bus_arbiter.sv
// Directed bench for the arbiter: grant order, bursts, writes, watchdog, reset.
module tb_dand_mem_bus_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic                  io_axiClk = 1'b0;
    logic                  io_axiReset;
    logic [1:0]            m_cmd_valid, m_cmd_write, m_cmd_ready, m_rsp_valid;
    logic [2*ADDR_W-1:0]   m_cmd_addr;
    logic [2*LEN_W-1:0]    m_cmd_len;
    logic [2*DATA_W-1:0]   m_cmd_wdata;
    logic [2*DATA_W/8-1:0] m_cmd_wstrb;
    logic [DATA_W-1:0]     m_rsp_data, s_cmd_wdata, s_rsp_data;
    logic                  m_rsp_last, m_rsp_error, s_cmd_valid, s_cmd_ready, s_cmd_write;
    logic [ADDR_W-1:0]     s_cmd_addr;
    logic [LEN_W-1:0]      s_cmd_len;
    logic [DATA_W/8-1:0]   s_cmd_wstrb;
    logic                  s_rsp_valid, s_rsp_last, s_rsp_error;
    logic                  busy, grant_id, timeout_pulse;

    int total = 0;
    int bad   = 0;

    dand_mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .io_axiClk(io_axiClk), .io_axiReset(io_axiReset),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_write(m_cmd_write),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len), .m_cmd_wdata(m_cmd_wdata),
        .m_cmd_wstrb(m_cmd_wstrb), .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .m_rsp_last(m_rsp_last), .m_rsp_error(m_rsp_error),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_write(s_cmd_write),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len), .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_wstrb(s_cmd_wstrb), .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data),
        .s_rsp_last(s_rsp_last), .s_rsp_error(s_rsp_error),
        .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
    );

    always #5 io_axiClk = ~io_axiClk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_axiClk);
        #1;
    endtask

    // Drive one slave beat, let it settle, then check the forwarded beat.
    task automatic rsp_beat(input string tag, input logic [63:0] d, input logic sl, input logic se,
                            input logic [1:0] ev, input logic el, input logic ee);
        s_rsp_valid = 1'b1; s_rsp_data = d; s_rsp_last = sl; s_rsp_error = se;
        #1;
        chk({tag, "_valid"}, 64'(m_rsp_valid), 64'(ev));
        chk({tag, "_data"}, m_rsp_data, d);
        chk({tag, "_last"}, 64'(m_rsp_last), 64'(el));
        chk({tag, "_err"}, 64'(m_rsp_error), 64'(ee));
        tick();
        s_rsp_valid = 1'b0; s_rsp_last = 1'b0; s_rsp_error = 1'b0;
    endtask

    initial begin
        io_axiReset = 1'b1;
        m_cmd_valid = 2'b00; m_cmd_write = 2'b00; m_cmd_addr = '0; m_cmd_len = '0;
        m_cmd_wdata = '0; m_cmd_wstrb = '0;
        s_cmd_ready = 1'b1; s_rsp_valid = 1'b0; s_rsp_data = '0; s_rsp_last = 1'b0; s_rsp_error = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_cmd_ready", 64'(m_cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("rst_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
        chk("rst_pulse", 64'(timeout_pulse), 64'd0);
        io_axiReset = 1'b0;

        // master 0 read, len=3 -> 4 beats
        m_cmd_valid = 2'b01; m_cmd_addr = {32'h0, 32'h0000_1000}; m_cmd_len = {8'd0, 8'd3};
        #1;
        chk("t1_idle_no_ready", 64'(m_cmd_ready), 64'd0);
        tick();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_s_valid", 64'(s_cmd_valid), 64'd1);
        chk("t1_ready", 64'(m_cmd_ready), 64'd1);
        chk("t1_addr", 64'(s_cmd_addr), 64'h1000);
        chk("t1_len", 64'(s_cmd_len), 64'd3);
        chk("t1_write", 64'(s_cmd_write), 64'd0);
        tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t1_b0", 64'h1111, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t1_b1", 64'h2222, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t1_b2", 64'h3333, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t1_b3", 64'h4444, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        chk("t1_idle", 64'(busy), 64'd0);

        // contested arbitration after a fresh reset: 0, then 1, then 0
        io_axiReset = 1'b1; tick(); io_axiReset = 1'b0;
        m_cmd_valid = 2'b11; m_cmd_addr = {32'hB0, 32'hA0}; m_cmd_len = '0;
        tick();
        chk("t2_g0", 64'(grant_id), 64'd0);
        chk("t2_ready0", 64'(m_cmd_ready), 64'd1);
        chk("t2_addr0", 64'(s_cmd_addr), 64'hA0);
        tick();
        m_cmd_valid = 2'b10;
        rsp_beat("t2_r0", 64'hAA, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        chk("t2_gap_busy", 64'(busy), 64'd0);
        chk("t2_gap_ready", 64'(m_cmd_ready), 64'd0);
        tick();
        chk("t2_g1", 64'(grant_id), 64'd1);
        chk("t2_ready1", 64'(m_cmd_ready), 64'd2);
        chk("t2_addr1", 64'(s_cmd_addr), 64'hB0);
        tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t2_r1", 64'hBB, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        m_cmd_valid = 2'b11;
        tick();
        chk("t2_g_alt", 64'(grant_id), 64'd0);
        tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t2_r2", 64'hCC, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);

        // master 1 single-beat write; len field ignored, missing slave last still ends it
        m_cmd_valid = 2'b10; m_cmd_write = 2'b10; m_cmd_addr = {32'h2000, 32'h0};
        m_cmd_len = {8'd5, 8'd0}; m_cmd_wdata = {64'hCAFE_F00D_1234_5678, 64'h0};
        m_cmd_wstrb = {8'hF0, 8'h00};
        tick();
        chk("t3_grant", 64'(grant_id), 64'd1);
        chk("t3_write", 64'(s_cmd_write), 64'd1);
        chk("t3_wstrb", 64'(s_cmd_wstrb), 64'hF0);
        chk("t3_wdata", s_cmd_wdata, 64'hCAFE_F00D_1234_5678);
        tick();
        m_cmd_valid = 2'b00; m_cmd_write = 2'b00;
        rsp_beat("t3_rsp", 64'h0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        chk("t3_idle", 64'(busy), 64'd0);

        // master 0 read len=7, slave stalls after 2 beats -> watchdog abort
        m_cmd_valid = 2'b01; m_cmd_addr = {32'h0, 32'h3000}; m_cmd_len = {8'd0, 8'd7};
        tick(); tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t4_b0", 64'h10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t4_b1", 64'h20, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        s_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            chk("t4_wait_pulse", 64'(timeout_pulse), 64'd0);
            tick();
        end
        chk("t4_abort_valid", 64'(m_rsp_valid), 64'd1);
        chk("t4_abort_last", 64'(m_rsp_last), 64'd1);
        chk("t4_abort_err", 64'(m_rsp_error), 64'd1);
        chk("t4_abort_data", m_rsp_data, 64'd0);
        chk("t4_abort_pulse", 64'(timeout_pulse), 64'd1);
        tick();
        chk("t4_pulse_off", 64'(timeout_pulse), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        s_rsp_valid = 1'b1;
        #1;
        chk("t4_late_beat", 64'(m_rsp_valid), 64'd0);
        tick();
        s_rsp_valid = 1'b0;
        chk("t4_still_idle", 64'(busy), 64'd0);

        // master 0 read len=5, slave ends early on the third beat
        m_cmd_valid = 2'b01; m_cmd_addr = {32'h0, 32'h4000}; m_cmd_len = {8'd0, 8'd5};
        tick(); tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t5_b0", 64'h51, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t5_b1", 64'h52, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        rsp_beat("t5_b2", 64'h53, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("t5_idle", 64'(busy), 64'd0);

        // reset during a master 1 burst, then contested request goes to master 0
        m_cmd_valid = 2'b10; m_cmd_addr = {32'h5000, 32'h0}; m_cmd_len = {8'd3, 8'd0};
        tick(); tick();
        m_cmd_valid = 2'b00;
        rsp_beat("t6_b0", 64'h61, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        s_rsp_valid = 1'b1; s_rsp_data = 64'h62; io_axiReset = 1'b1;
        tick();
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("t6_cmd_ready", 64'(m_cmd_ready), 64'd0);
        chk("t6_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
        chk("t6_pulse", 64'(timeout_pulse), 64'd0);
        chk("t6_grant", 64'(grant_id), 64'd0);
        s_rsp_valid = 1'b0; io_axiReset = 1'b0;
        m_cmd_valid = 2'b11; m_cmd_addr = {32'hB6, 32'hA6}; m_cmd_len = '0;
        tick();
        chk("t6_contest_grant", 64'(grant_id), 64'd0);
        chk("t6_contest_ready", 64'(m_cmd_ready), 64'd1);
        m_cmd_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dand_mem_bus_arbiter.md
Name: dand_mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter sharing the SoC memory port between the core instruction fetch (master 0) and the core data port (master 1).
- Grant policy is round-robin. Once a master is granted, it holds the grant for the whole transaction, from the command handshake through the final response beat.
- A response watchdog aborts hung transactions and returns an error beat to the waiting master.
- Sits between the core bus interfaces and the AXI bridge, in the io_axiClk domain.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width
- LEN_W, 8, burst length field width (read beats = len+1)
- TIMEOUT, 1024, max cycles between command accept and a response beat, or between consecutive beats; must be ≥2

Ports:
- io_axiClk  in  1  clock
- io_axiReset  in  1  synchronous active-high reset
- m_cmd_valid  in  2  per-master command valid (bit i = master i)
- m_cmd_ready  out  2  per-master command accept
- m_cmd_write  in  2  1 = single-beat write, 0 = read burst
- m_cmd_addr  in  2*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- m_cmd_len  in  2*LEN_W  packed read length-1, ignored for writes
- m_cmd_wdata  in  2*DATA_W  packed write data
- m_cmd_wstrb  in  2*DATA_W/8  packed byte strobes
- m_rsp_valid  out  2  per-master response beat; masters always accept
- m_rsp_data  out  DATA_W  shared response data, qualified by m_rsp_valid
- m_rsp_last  out  1  final beat of a transaction
- m_rsp_error  out  1  beat is a timeout or protocol error
- s_cmd_valid/s_cmd_ready/s_cmd_write/s_cmd_addr/s_cmd_len/s_cmd_wdata/s_cmd_wstrb  out/in/out/out/out/out/out  1/1/1/ADDR_W/LEN_W/DATA_W/DATA_W/8  slave command
- s_rsp_valid  in  1  slave response beat
- s_rsp_data  in  DATA_W  slave response data
- s_rsp_last  in  1  slave final beat
- s_rsp_error  in  1  slave error
- busy  out  1  state != IDLE
- grant_id  out  1  current or last grant
- timeout_pulse  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (io_axiReset=1 at a rising edge):
  - state=IDLE, last_grant=1 so master 0 wins first, beat_cnt=0, wd_cnt=0.
  - All valid/ready/pulse outputs 0, grant_id=0.
  - Reset mid-transaction drops everything at the next edge; the slave is reset by the same signal.
- States: IDLE, CMD, RSP.
- IDLE:
  - If neither m_cmd_valid bit is set, stay in IDLE.
  - If exactly one is set, grant that master.
  - If both are set, grant ~last_grant.
  - The grant is registered, then go to CMD. Arbitration costs 1 cycle; no m_cmd_ready in IDLE.
- CMD:
  - s_cmd_* is muxed combinationally from the granted master, s_cmd_valid=1.
  - m_cmd_ready[g]=s_cmd_ready; the other bit stays 0.
  - On handshake: beat_cnt = write ? 0 : len, wd_cnt=0, go to RSP.
  - No watchdog runs in CMD. The master must hold its fields stable until accepted.
- RSP:
  - m_rsp_valid[g]=s_rsp_valid, data passes through combinationally, m_rsp_error=s_rsp_error.
  - m_rsp_last = s_rsp_valid && (beat_cnt==0 || s_rsp_last).
  - Each beat decrements beat_cnt. On the last beat: last_grant<=g, go to IDLE.
  - Early s_rsp_last (beat_cnt≠0) ends the transaction with m_rsp_error=1 on that beat.
  - s_rsp_last missing on a beat where beat_cnt==0 is still treated as last.
- Watchdog:
  - In RSP, wd_cnt increments each cycle without s_rsp_valid and clears on each beat.
  - When wd_cnt==TIMEOUT-1 and no beat arrives, the arbiter emits one abort beat: m_rsp_valid[g]=1, data=0, last=1, error=1, timeout_pulse=1. Then go to IDLE.
  - Slave beats after an abort, while in IDLE/CMD, are discarded.
- Simultaneous events: a new m_cmd_valid in the final-beat cycle is not granted until the following IDLE cycle. Back-to-back transactions therefore have ≥1 idle cycle.
- Widths: beat_cnt LEN_W bits, wd_cnt $clog2(TIMEOUT) bits; no wrap possible.

Decomposition:
- Package dand_bus_pkg: state enum, DATA_W/ADDR_W/LEN_W defaults, master index constants IBUS=0, DBUS=1.
- One sub-module, dand_rr_arbiter2: 2-request round-robin picker with last_grant register. Everything else stays in the top level.

Test Plan:
- Single master 0 read, len=3, slave returns 4 beats: grant in cycle 1, handshake in cycle 2, then 4 m_rsp_valid[0] beats with last on the 4th; busy deasserts on the following cycle.
- Both masters assert reads in the same cycle after reset: master 0 is served first, then master 1; repeat with both asserting again → master 0 again (alternation).
- Master 1 write with wstrb=0xF0, single response beat: m_rsp_last=1, error=0, returns to IDLE.
- Read len=7, slave stalls after beat 2 for TIMEOUT cycles: abort beat with error=1, last=1, data=0, timeout_pulse for one cycle; a late slave beat is ignored.
- Read len=5, slave asserts s_rsp_last on beat 3: that beat carries last=1 and error=1, then IDLE.
- io_axiReset asserted in the middle of a read burst: all outputs 0 on the next edge; after release, master 0 wins a contested arbitration.
